// File: rtl/nrisc_pkg.sv
// nrisc_pkg: opcodes, fetch-sequencer states and reset constants shared by the nRisc core.
package nrisc_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    typedef enum logic [2:0] {S_FETCH, S_LOAD, S_EXEC, S_UPDATE, S_HALTED} fetch_state_e;
    // Halt opcode in the IR keeps the control unit idle until the first real fetch.
    localparam logic [7:0] IR_RESET = 8'hE0;
endpackage

// File: rtl/nrisc_fetch_if.sv
// nrisc_fetch_if: instruction memory, control-unit strobes and status between the fetch unit and its environment.
interface nrisc_fetch_if #(parameter int PC_W = 8, parameter int CNT_W = 16);
    logic [7:0]      ImemData;
    logic            Branch, Jump, EscPc, Zero, Stall, Resume;
    logic [PC_W-1:0] ImemAddr, PC;
    logic [2:0]      OPcode;
    logic [4:0]      Operand;
    logic            InstrDone, Halted;
    logic [CNT_W-1:0] Retired;
    modport master (
        input  ImemData, Branch, Jump, EscPc, Zero, Stall, Resume,
        output ImemAddr, OPcode, Operand, PC, InstrDone, Halted, Retired
    );
    modport slave (
        output ImemData, Branch, Jump, EscPc, Zero, Stall, Resume,
        input  ImemAddr, OPcode, Operand, PC, InstrDone, Halted, Retired
    );
endinterface

// File: rtl/nrisc_pc_next.sv
// nrisc_pc_next: next-PC select (hold, page-relative jump, relative branch, sequential), all modulo 2^PC_W.
module nrisc_pc_next #(parameter int PC_W = 8) (
    input  logic [PC_W-1:0] pc,
    input  logic [4:0]      operand,
    input  logic            hold,
    input  logic            jump,
    input  logic            branch,
    input  logic            zero,
    output logic [PC_W-1:0] pc_next
);
    logic [PC_W-1:0] seq, offset;
    assign seq = pc + PC_W'(1);
    assign offset = {{(PC_W-5){operand[4]}}, operand};
    always_comb
        pc_next = hold ? pc :
                  jump ? {pc[PC_W-1:5], operand} :
                  (branch && zero) ? seq + offset : seq;
endmodule

// File: rtl/nrisc_fetch.sv
// nrisc_fetch: PC/IR owner and FETCH-LOAD-EXEC-UPDATE sequencer with halt, resume, stall
// and a saturating retired-instruction counter.
module nrisc_fetch import nrisc_pkg::*; #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input logic Clock,
    input logic Reset,
    nrisc_fetch_if.master bus
);
    fetch_state_e     state;
    logic [7:0]       ir;
    logic [PC_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0] retired;
    logic [2:0]       op;
    logic             halt, jump_q, branch_q;
    assign op = ir[7:5];
    // Strobes are only looked at for their own opcode, so stale or X strobes cannot leak in.
    assign jump_q   = (op == OP_JMP) ? bus.Jump : 1'b0;
    assign branch_q = (op == OP_BEQ) ? bus.Branch : 1'b0;
    assign halt     = (op == OP_HALT) || !bus.EscPc;
    nrisc_pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc),
        .operand (ir[4:0]),
        .hold    (halt),
        .jump    (jump_q),
        .branch  (branch_q),
        .zero    (bus.Zero),
        .pc_next (pc_nxt)
    );
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_FETCH;
            pc      <= PC_W'(RESET_PC);
            ir      <= IR_RESET;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    ir    <= bus.ImemData;
                    state <= S_EXEC;
                end
                S_EXEC: if (!bus.Stall) state <= S_UPDATE;
                S_UPDATE: begin
                    pc <= pc_nxt;
                    if (halt) state <= S_HALTED;
                    else begin
                        retired <= (&retired) ? retired : retired + CNT_W'(1);
                        state   <= S_FETCH;
                    end
                end
                S_HALTED: if (bus.Resume) begin
                    pc    <= pc + PC_W'(1);
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
    // Strobes only settle in UPDATE, so the retire pulse is decoded from the state there.
    assign bus.InstrDone = (state == S_UPDATE) && !halt;
    assign bus.Halted    = (state == S_HALTED);
    assign bus.OPcode    = (state == S_HALTED) ? OP_HALT : op;
    assign bus.Operand   = ir[4:0];
    assign bus.ImemAddr  = pc;
    assign bus.PC        = pc;
    assign bus.Retired   = retired;
endmodule

// File: tb/tb_nrisc_fetch.sv
// tb_nrisc_fetch: directed scenarios against a synchronous instruction memory and hand-driven strobes.
module tb_nrisc_fetch;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic rst2 = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] d1, d2;
    int checks = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    nrisc_fetch_if #(.PC_W(8), .CNT_W(16)) b1 ();
    nrisc_fetch_if #(.PC_W(8), .CNT_W(3)) b2 ();

    nrisc_fetch #(.PC_W(8), .RESET_PC(0), .CNT_W(16)) dut (.Clock(Clock), .Reset(Reset), .bus(b1));
    nrisc_fetch #(.PC_W(8), .RESET_PC(0), .CNT_W(3)) dut_sat (.Clock(Clock), .Reset(rst2), .bus(b2));

    always @(posedge Clock) begin
        d1 <= mem[b1.ImemAddr];
        d2 <= mem[b2.ImemAddr];
    end
    assign b1.ImemData = d1;
    assign b2.ImemData = d2;

    task automatic do_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Called at a FETCH-cycle negedge; returns the cycle of InstrDone (FETCH = 1), 0 on timeout.
    task automatic step(output int n);
        n = 1;
        while (b1.InstrDone !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (b1.InstrDone !== 1'b1) n = 0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        mem[8'h00] = 8'h01;
        mem[8'h01] = 8'h21;
        b1.Branch = 0; b1.Jump = 0; b1.EscPc = 1; b1.Zero = 0; b1.Stall = 0; b1.Resume = 0;
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({b1.OPcode, b1.Operand, b1.InstrDone, b1.Halted} !== {3'd7, 5'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctl: got op=%b opd=%h done=%b halted=%b expected op=111 opd=00 done=0 halted=0",
                     b1.OPcode, b1.Operand, b1.InstrDone, b1.Halted);
        end
        checks++;
        if ({b1.PC, b1.ImemAddr, b1.Retired} !== {8'h00, 8'h00, 16'h0000}) begin
            fails++;
            $display("FAIL reset_pc: got pc=%h addr=%h retired=%h expected 00 00 0000", b1.PC, b1.ImemAddr, b1.Retired);
        end
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({b1.OPcode, b1.Operand} !== {3'b000, 5'h01}) begin
            fails++;
            $display("FAIL first_ir: got op=%b opd=%h expected op=000 opd=01", b1.OPcode, b1.Operand);
        end
        @(negedge Clock);
        checks++;
        if (b1.InstrDone !== 1'b1) begin
            fails++;
            $display("FAIL first_done: got %b expected 1 in cycle 4", b1.InstrDone);
        end
        @(negedge Clock);
        checks++;
        if ({b1.PC, b1.Retired, b1.InstrDone} !== {8'h01, 16'd1, 1'b0}) begin
            fails++;
            $display("FAIL first_retire: got pc=%h retired=%0d done=%b expected 01 1 0", b1.PC, b1.Retired, b1.InstrDone);
        end
    endtask

    task automatic test_jump();
        int n;
        mem[8'h00] = 8'h6F;
        mem[8'h10] = 8'h6F;
        mem[8'h20] = 8'h85;
        mem[8'h25] = 8'h83;
        mem[8'h23] = 8'h03;
        b1.Branch = 1; b1.Zero = 1; b1.Jump = 1; b1.EscPc = 1;
        do_reset();
        step(n);
        step(n);
        step(n);
        checks++;
        if (b1.PC !== 8'h25) begin
            fails++;
            $display("FAIL jump_setup: got pc=%h expected 25", b1.PC);
        end
        step(n);
        checks++;
        if (b1.PC !== 8'h23 || n != 4) begin
            fails++;
            $display("FAIL jump_taken: got pc=%h cycles=%0d expected 23 4", b1.PC, n);
        end
        step(n);
        checks++;
        if (b1.PC !== 8'h24 || b1.Retired !== 16'd5) begin
            fails++;
            $display("FAIL jump_unqualified: got pc=%h retired=%0d expected 24 5", b1.PC, b1.Retired);
        end
    endtask

    task automatic test_branch();
        int n;
        mem[8'h00] = 8'h6F;
        mem[8'h10] = 8'h7E;
        mem[8'h0F] = 8'h00;
        b1.Branch = 1; b1.Zero = 1; b1.Jump = 0; b1.EscPc = 1;
        do_reset();
        step(n);
        step(n);
        checks++;
        if (b1.PC !== 8'h0F) begin
            fails++;
            $display("FAIL branch_taken: got pc=%h expected 0f", b1.PC);
        end
        step(n);
        b1.Zero = 0;
        step(n);
        checks++;
        if (b1.PC !== 8'h11) begin
            fails++;
            $display("FAIL branch_not_taken: got pc=%h expected 11", b1.PC);
        end
        mem[8'h00] = 8'h7E;
        mem[8'hFF] = 8'h61;
        mem[8'h01] = 8'h7F;
        b1.Zero = 1;
        do_reset();
        step(n);
        checks++;
        if (b1.PC !== 8'hFF) begin
            fails++;
            $display("FAIL branch_neg_wrap: got pc=%h expected ff", b1.PC);
        end
        step(n);
        checks++;
        if (b1.PC !== 8'h01) begin
            fails++;
            $display("FAIL branch_pos_wrap: got pc=%h expected 01", b1.PC);
        end
        step(n);
        step(n);
        checks++;
        if (b1.PC !== 8'h01 || n != 4 || b1.Retired !== 16'd4) begin
            fails++;
            $display("FAIL branch_self_loop: got pc=%h cycles=%0d retired=%0d expected 01 4 4", b1.PC, n, b1.Retired);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [2:0] op_mid;
        mem[8'h00] = 8'h84;
        mem[8'h04] = 8'hC0;
        mem[8'h05] = 8'hE0;
        b1.Branch = 0; b1.Zero = 0; b1.Jump = 1; b1.EscPc = 1;
        do_reset();
        step(n);
        b1.Stall = 1;
        n = 1;
        op_mid = 3'b000;
        while (b1.InstrDone !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
            if (n == 5) op_mid = b1.OPcode;
            if (n == 6) b1.Stall = 0;
        end
        @(negedge Clock);
        checks++;
        if (n != 7 || b1.PC !== 8'h05 || op_mid !== 3'b110) begin
            fails++;
            $display("FAIL stall_lw: got cycles=%0d pc=%h op=%b expected 7 05 110", n, b1.PC, op_mid);
        end
        b1.Stall = 1;
        n = 1;
        while (b1.Halted !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
            if (n == 5) b1.Stall = 0;
        end
        checks++;
        if (n != 7 || b1.PC !== 8'h05) begin
            fails++;
            $display("FAIL stall_then_halt: got cycles=%0d pc=%h expected 7 05", n, b1.PC);
        end
    endtask

    task automatic test_halt();
        int n;
        logic seen_done, moved;
        mem[8'h00] = 8'hE0;
        mem[8'h01] = 8'h20;
        mem[8'h02] = 8'h00;
        b1.Branch = 0; b1.Zero = 0; b1.Jump = 0; b1.EscPc = 1; b1.Stall = 0; b1.Resume = 0;
        do_reset();
        n = 1;
        seen_done = 0;
        while (b1.Halted !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
            seen_done |= b1.InstrDone;
        end
        checks++;
        if (n != 5 || seen_done !== 1'b0) begin
            fails++;
            $display("FAIL halt_enter: got cycles=%0d done_seen=%b expected 5 0", n, seen_done);
        end
        moved = 0;
        repeat (20) begin
            @(negedge Clock);
            moved |= (b1.PC !== 8'h00) || (b1.Halted !== 1'b1);
            seen_done |= b1.InstrDone;
        end
        checks++;
        if (moved !== 1'b0 || seen_done !== 1'b0 || b1.OPcode !== 3'b111 || b1.Retired !== 16'd0) begin
            fails++;
            $display("FAIL halt_frozen: got moved=%b done_seen=%b op=%b retired=%0d expected 0 0 111 0",
                     moved, seen_done, b1.OPcode, b1.Retired);
        end
        b1.Resume = 1;
        @(negedge Clock);
        b1.Resume = 0;
        checks++;
        if (b1.PC !== 8'h01 || b1.Halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_resume: got pc=%h halted=%b expected 01 0", b1.PC, b1.Halted);
        end
        b1.EscPc = 0;
        n = 1;
        while (b1.Halted !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (n != 5 || b1.OPcode !== 3'b111 || b1.PC !== 8'h01) begin
            fails++;
            $display("FAIL escpc_halt: got cycles=%0d op=%b pc=%h expected 5 111 01", n, b1.OPcode, b1.PC);
        end
        b1.Resume = 1;
        b1.EscPc = 1;
        @(negedge Clock);
        step(n);
        b1.Resume = 0;
        checks++;
        if (b1.PC !== 8'h03 || b1.Retired !== 16'd1 || n != 4) begin
            fails++;
            $display("FAIL resume_ignored: got pc=%h retired=%0d cycles=%0d expected 03 1 4", b1.PC, b1.Retired, n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mem[8'h00] = 8'h84;
        mem[8'h04] = 8'hC5;
        b1.Branch = 0; b1.Zero = 0; b1.Jump = 1; b1.EscPc = 1; b1.Resume = 0;
        do_reset();
        step(n);
        b1.Stall = 1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({b1.OPcode, b1.Operand, b1.PC} !== {3'b110, 5'h05, 8'h04}) begin
            fails++;
            $display("FAIL mid_pre: got op=%b opd=%h pc=%h expected 110 05 04", b1.OPcode, b1.Operand, b1.PC);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({b1.OPcode, b1.Operand, b1.InstrDone, b1.Halted, b1.PC, b1.ImemAddr, b1.Retired} !==
            {3'd7, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0}) begin
            fails++;
            $display("FAIL mid_reset: got op=%b opd=%h done=%b halted=%b pc=%h addr=%h retired=%0d expected 111 00 0 0 00 00 0",
                     b1.OPcode, b1.Operand, b1.InstrDone, b1.Halted, b1.PC, b1.ImemAddr, b1.Retired);
        end
        b1.Stall = 0;
        @(negedge Clock);
        Reset = 1'b1;
        step(n);
        checks++;
        if (b1.PC !== 8'h04 || n != 4) begin
            fails++;
            $display("FAIL mid_restart: got pc=%h cycles=%0d expected 04 4", b1.PC, n);
        end
    endtask

    task automatic test_saturate();
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst2 = 1'b0;
        @(negedge Clock);
        rst2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n = 1;
            while (b2.InstrDone !== 1'b1 && n < 40) begin
                @(negedge Clock);
                n++;
            end
            @(negedge Clock);
            if (k == 7) begin
                checks++;
                if (b2.Retired !== 3'd7) begin
                    fails++;
                    $display("FAIL sat_reach: got retired=%0d expected 7", b2.Retired);
                end
            end
            if (k == 8) begin
                checks++;
                if (b2.Retired !== 3'd7 || b2.PC !== 8'h08) begin
                    fails++;
                    $display("FAIL sat_hold: got retired=%0d pc=%h expected 7 08", b2.Retired, b2.PC);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        b2.Branch = 0; b2.Jump = 0; b2.EscPc = 1; b2.Zero = 0; b2.Stall = 0; b2.Resume = 0;
        test_reset();
        test_jump();
        test_branch();
        test_stall();
        test_halt();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
